// File: rtl/axil_bridge_1xm.sv
// AXI4-Lite 1-to-M address-decoding bridge.
// One upstream master fans out to M downstream slaves by address window.
// Unmapped addresses are answered locally with DECERR. Write and read paths
// are independent FSMs with one outstanding transaction each.
module axil_bridge_1xm #(
    parameter int M          = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter logic [M*ADDR_WIDTH-1:0] BASE_ADDR_PACKED =
        {32'h3000, 32'h2000, 32'h1000, 32'h0000},
    parameter logic [M*ADDR_WIDTH-1:0] SIZE_PACKED = {4{32'h1000}}
) (
    input  logic                         clk,
    input  logic                         rst,
    // upstream write address / data / response
    input  logic [ADDR_WIDTH-1:0]        up_aw_addr,
    input  logic                         up_aw_valid,
    output logic                         up_aw_ready,
    input  logic [DATA_WIDTH-1:0]        up_w_data,
    input  logic [DATA_WIDTH/8-1:0]      up_w_strb,
    input  logic                         up_w_valid,
    output logic                         up_w_ready,
    output logic [1:0]                   up_b_resp,
    output logic                         up_b_valid,
    input  logic                         up_b_ready,
    // upstream read address / data
    input  logic [ADDR_WIDTH-1:0]        up_ar_addr,
    input  logic                         up_ar_valid,
    output logic                         up_ar_ready,
    output logic [DATA_WIDTH-1:0]        up_r_data,
    output logic [1:0]                   up_r_resp,
    output logic                         up_r_valid,
    input  logic                         up_r_ready,
    // downstream ports, slave i in slice i
    output logic [M*ADDR_WIDTH-1:0]      dn_aw_addr,
    output logic [M-1:0]                 dn_aw_valid,
    input  logic [M-1:0]                 dn_aw_ready,
    output logic [M*DATA_WIDTH-1:0]      dn_w_data,
    output logic [M*DATA_WIDTH/8-1:0]    dn_w_strb,
    output logic [M-1:0]                 dn_w_valid,
    input  logic [M-1:0]                 dn_w_ready,
    input  logic [M*2-1:0]               dn_b_resp,
    input  logic [M-1:0]                 dn_b_valid,
    output logic [M-1:0]                 dn_b_ready,
    output logic [M*ADDR_WIDTH-1:0]      dn_ar_addr,
    output logic [M-1:0]                 dn_ar_valid,
    input  logic [M-1:0]                 dn_ar_ready,
    input  logic [M*DATA_WIDTH-1:0]      dn_r_data,
    input  logic [M*2-1:0]               dn_r_resp,
    input  logic [M-1:0]                 dn_r_valid,
    output logic [M-1:0]                 dn_r_ready
);

    localparam int IW = (M > 1) ? $clog2(M) : 1;
    localparam logic [1:0] DECERR = 2'b11;

    typedef struct packed {
        logic          hit;
        logic [IW-1:0] idx;
    } dec_t;

    typedef enum logic [2:0] {WR_IDLE, WR_FWD, WR_RESP, WR_ERR_W, WR_ERR_B} wr_state_t;
    typedef enum logic [1:0] {RD_IDLE, RD_FWD, RD_RESP, RD_ERR} rd_state_t;

    // Window compare is done one bit wider so base+size cannot wrap.
    // Scanning downwards lets the lowest matching index win.
    function automatic dec_t decode(input logic [ADDR_WIDTH-1:0] addr);
        dec_t d;
        logic [ADDR_WIDTH:0] a, lo, hi;
        d = '0;
        a = {1'b0, addr};
        for (int i = M - 1; i >= 0; i--) begin
            lo = {1'b0, BASE_ADDR_PACKED[i*ADDR_WIDTH +: ADDR_WIDTH]};
            hi = lo + {1'b0, SIZE_PACKED[i*ADDR_WIDTH +: ADDR_WIDTH]};
            if (a >= lo && a < hi) begin
                d.hit = 1'b1;
                d.idx = IW'(i);
            end
        end
        return d;
    endfunction

    dec_t aw_dec, ar_dec;
    assign aw_dec = decode(up_aw_addr);
    assign ar_dec = decode(up_ar_addr);

    // Unpacked views of the per-slave response buses for indexed muxing.
    logic [1:0]            b_resp_a [M];
    logic [DATA_WIDTH-1:0] r_data_a [M];
    logic [1:0]            r_resp_a [M];

    for (genvar g = 0; g < M; g++) begin : g_unpack
        assign b_resp_a[g] = dn_b_resp[g*2 +: 2];
        assign r_data_a[g] = dn_r_data[g*DATA_WIDTH +: DATA_WIDTH];
        assign r_resp_a[g] = dn_r_resp[g*2 +: 2];
    end

    wr_state_t             wr_state, wr_next;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [IW-1:0]         wr_sel;
    logic                  aw_done, aw_done_n, w_done, w_done_n;

    rd_state_t             rd_state, rd_next;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [IW-1:0]         rd_sel;

    // Address and W payload are broadcast; only valid/ready are steered.
    assign dn_aw_addr = {M{wr_addr}};
    assign dn_ar_addr = {M{rd_addr}};
    assign dn_w_data  = {M{up_w_data}};
    assign dn_w_strb  = {M{up_w_strb}};

    // Write path state, latched address/index and AW/W completion flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state <= WR_IDLE;
            wr_addr  <= '0;
            wr_sel   <= '0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
        end else begin
            wr_state <= wr_next;
            aw_done  <= aw_done_n;
            w_done   <= w_done_n;
            if (wr_state == WR_IDLE && up_aw_valid) begin
                wr_addr <= up_aw_addr;
                wr_sel  <= aw_dec.idx;
            end
        end
    end

    // Write next-state and handshake steering.
    always_comb begin
        wr_next     = wr_state;
        aw_done_n   = aw_done;
        w_done_n    = w_done;
        up_aw_ready = 1'b0;
        up_w_ready  = 1'b0;
        up_b_valid  = 1'b0;
        up_b_resp   = 2'b00;
        dn_aw_valid = '0;
        dn_w_valid  = '0;
        dn_b_ready  = '0;
        case (wr_state)
            WR_IDLE: begin
                up_aw_ready = 1'b1;
                aw_done_n   = 1'b0;
                w_done_n    = 1'b0;
                if (up_aw_valid)
                    wr_next = aw_dec.hit ? WR_FWD : WR_ERR_W;
            end
            WR_FWD: begin
                // AW and W finish independently; either may come first.
                dn_aw_valid[wr_sel] = !aw_done;
                dn_w_valid[wr_sel]  = up_w_valid && !w_done;
                up_w_ready          = dn_w_ready[wr_sel] && !w_done;
                if (!aw_done && dn_aw_ready[wr_sel])
                    aw_done_n = 1'b1;
                if (up_w_valid && up_w_ready)
                    w_done_n = 1'b1;
                if (aw_done_n && w_done_n)
                    wr_next = WR_RESP;
            end
            WR_RESP: begin
                up_b_valid         = dn_b_valid[wr_sel];
                up_b_resp          = b_resp_a[wr_sel];
                dn_b_ready[wr_sel] = up_b_ready;
                if (dn_b_valid[wr_sel] && up_b_ready)
                    wr_next = WR_IDLE;
            end
            WR_ERR_W: begin
                up_w_ready = 1'b1;
                if (up_w_valid)
                    wr_next = WR_ERR_B;
            end
            WR_ERR_B: begin
                up_b_valid = 1'b1;
                up_b_resp  = DECERR;
                if (up_b_ready)
                    wr_next = WR_IDLE;
            end
            default: wr_next = WR_IDLE;
        endcase
    end

    // Read path state and latched address/index.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state <= RD_IDLE;
            rd_addr  <= '0;
            rd_sel   <= '0;
        end else begin
            rd_state <= rd_next;
            if (rd_state == RD_IDLE && up_ar_valid) begin
                rd_addr <= up_ar_addr;
                rd_sel  <= ar_dec.idx;
            end
        end
    end

    // Read next-state and response steering.
    always_comb begin
        rd_next     = rd_state;
        up_ar_ready = 1'b0;
        up_r_valid  = 1'b0;
        up_r_data   = '0;
        up_r_resp   = 2'b00;
        dn_ar_valid = '0;
        dn_r_ready  = '0;
        case (rd_state)
            RD_IDLE: begin
                up_ar_ready = 1'b1;
                if (up_ar_valid)
                    rd_next = ar_dec.hit ? RD_FWD : RD_ERR;
            end
            RD_FWD: begin
                dn_ar_valid[rd_sel] = 1'b1;
                if (dn_ar_ready[rd_sel])
                    rd_next = RD_RESP;
            end
            RD_RESP: begin
                up_r_valid         = dn_r_valid[rd_sel];
                up_r_data          = r_data_a[rd_sel];
                up_r_resp          = r_resp_a[rd_sel];
                dn_r_ready[rd_sel] = up_r_ready;
                if (dn_r_valid[rd_sel] && up_r_ready)
                    rd_next = RD_IDLE;
            end
            RD_ERR: begin
                up_r_valid = 1'b1;
                up_r_resp  = DECERR;
                if (up_r_ready)
                    rd_next = RD_IDLE;
            end
            default: rd_next = RD_IDLE;
        endcase
    end

endmodule

// File: tb/tb_axil_bridge_1xm.sv
// Directed bench for axil_bridge_1xm: four behavioural slaves with small
// memories, an upstream master driven from one linear initial block.
module tb_axil_bridge_1xm;

    localparam int M  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SB = DW / 8;

    logic clk, rst;
    logic [AW-1:0]   up_aw_addr;
    logic            up_aw_valid, up_aw_ready;
    logic [DW-1:0]   up_w_data;
    logic [SB-1:0]   up_w_strb;
    logic            up_w_valid, up_w_ready;
    logic [1:0]      up_b_resp;
    logic            up_b_valid, up_b_ready;
    logic [AW-1:0]   up_ar_addr;
    logic            up_ar_valid, up_ar_ready;
    logic [DW-1:0]   up_r_data;
    logic [1:0]      up_r_resp;
    logic            up_r_valid, up_r_ready;
    logic [M*AW-1:0] dn_aw_addr;
    logic [M-1:0]    dn_aw_valid, dn_aw_ready;
    logic [M*DW-1:0] dn_w_data;
    logic [M*SB-1:0] dn_w_strb;
    logic [M-1:0]    dn_w_valid, dn_w_ready;
    logic [M*2-1:0]  dn_b_resp;
    logic [M-1:0]    dn_b_valid, dn_b_ready;
    logic [M*AW-1:0] dn_ar_addr;
    logic [M-1:0]    dn_ar_valid, dn_ar_ready;
    logic [M*DW-1:0] dn_r_data;
    logic [M*2-1:0]  dn_r_resp;
    logic [M-1:0]    dn_r_valid, dn_r_ready;

    axil_bridge_1xm dut (
        .clk(clk), .rst(rst),
        .up_aw_addr(up_aw_addr), .up_aw_valid(up_aw_valid), .up_aw_ready(up_aw_ready),
        .up_w_data(up_w_data), .up_w_strb(up_w_strb), .up_w_valid(up_w_valid),
        .up_w_ready(up_w_ready),
        .up_b_resp(up_b_resp), .up_b_valid(up_b_valid), .up_b_ready(up_b_ready),
        .up_ar_addr(up_ar_addr), .up_ar_valid(up_ar_valid), .up_ar_ready(up_ar_ready),
        .up_r_data(up_r_data), .up_r_resp(up_r_resp), .up_r_valid(up_r_valid),
        .up_r_ready(up_r_ready),
        .dn_aw_addr(dn_aw_addr), .dn_aw_valid(dn_aw_valid), .dn_aw_ready(dn_aw_ready),
        .dn_w_data(dn_w_data), .dn_w_strb(dn_w_strb), .dn_w_valid(dn_w_valid),
        .dn_w_ready(dn_w_ready),
        .dn_b_resp(dn_b_resp), .dn_b_valid(dn_b_valid), .dn_b_ready(dn_b_ready),
        .dn_ar_addr(dn_ar_addr), .dn_ar_valid(dn_ar_valid), .dn_ar_ready(dn_ar_ready),
        .dn_r_data(dn_r_data), .dn_r_resp(dn_r_resp), .dn_r_valid(dn_r_valid),
        .dn_r_ready(dn_r_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural slaves ----------------
    logic          aw_rdy_en;
    logic [M-1:0]  s_aw_got, s_w_got, s_b_pend, s_r_pend;
    logic [AW-1:0] s_awa [M];
    logic [DW-1:0] s_wd  [M];
    logic [SB-1:0] s_ws  [M];
    logic [DW-1:0] s_rd  [M];
    logic [DW-1:0] smem  [M][1024];
    int aw_cnt [M], w_cnt [M], ar_cnt [M];

    assign dn_aw_ready = aw_rdy_en ? {M{1'b1}} : {M{1'b0}};
    assign dn_w_ready  = {M{1'b1}};
    assign dn_ar_ready = {M{1'b1}};
    assign dn_b_valid  = s_b_pend;
    assign dn_b_resp   = '0;
    assign dn_r_valid  = s_r_pend;
    assign dn_r_resp   = '0;

    always_comb begin
        dn_r_data = '0;
        for (int i = 0; i < M; i++) dn_r_data[i*DW +: DW] = s_rd[i];
    end

    initial begin
        for (int i = 0; i < M; i++) begin
            aw_cnt[i] = 0; w_cnt[i] = 0; ar_cnt[i] = 0;
            s_rd[i] = '0; s_awa[i] = '0; s_wd[i] = '0; s_ws[i] = '0;
            for (int j = 0; j < 1024; j++) smem[i][j] = '0;
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            s_aw_got <= '0; s_w_got <= '0; s_b_pend <= '0; s_r_pend <= '0;
        end else begin
            for (int i = 0; i < M; i++) begin
                if (dn_aw_valid[i] && dn_aw_ready[i]) begin
                    s_aw_got[i] <= 1'b1;
                    s_awa[i]    <= dn_aw_addr[i*AW +: AW];
                    aw_cnt[i]   <= aw_cnt[i] + 1;
                end
                if (dn_w_valid[i] && dn_w_ready[i]) begin
                    s_w_got[i] <= 1'b1;
                    s_wd[i]    <= dn_w_data[i*DW +: DW];
                    s_ws[i]    <= dn_w_strb[i*SB +: SB];
                    w_cnt[i]   <= w_cnt[i] + 1;
                end
                if (s_aw_got[i] && s_w_got[i] && !s_b_pend[i]) begin
                    for (int b = 0; b < SB; b++)
                        if (s_ws[i][b]) smem[i][s_awa[i][11:2]][b*8 +: 8] <= s_wd[i][b*8 +: 8];
                    s_b_pend[i] <= 1'b1;
                    s_aw_got[i] <= 1'b0;
                    s_w_got[i]  <= 1'b0;
                end
                if (s_b_pend[i] && dn_b_ready[i]) s_b_pend[i] <= 1'b0;
                if (dn_ar_valid[i] && dn_ar_ready[i]) begin
                    s_r_pend[i] <= 1'b1;
                    s_rd[i]     <= smem[i][dn_ar_addr[i*AW+2 +: 10]];
                    ar_cnt[i]   <= ar_cnt[i] + 1;
                end
                if (s_r_pend[i] && dn_r_ready[i]) s_r_pend[i] <= 1'b0;
            end
        end
    end

    // ---------------- checking helpers ----------------
    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    int snap_aw [M], snap_w [M], snap_ar [M];

    task automatic snap();
        for (int i = 0; i < M; i++) begin
            snap_aw[i] = aw_cnt[i]; snap_w[i] = w_cnt[i]; snap_ar[i] = ar_cnt[i];
        end
    endtask

    // sel < 0 means no downstream slave may have been touched.
    task automatic chk_route(input string tag, input int sel, input bit is_wr);
        logic [M-1:0] exp_m, aw_m, w_m, ar_m;
        exp_m = '0;
        if (sel >= 0) exp_m[sel] = 1'b1;
        for (int i = 0; i < M; i++) begin
            aw_m[i] = (aw_cnt[i] != snap_aw[i]);
            w_m[i]  = (w_cnt[i]  != snap_w[i]);
            ar_m[i] = (ar_cnt[i] != snap_ar[i]);
        end
        if (is_wr) begin
            check({tag, "_aw_route"}, 64'(aw_m), 64'(exp_m));
            check({tag, "_w_route"},  64'(w_m),  64'(exp_m));
        end else begin
            check({tag, "_ar_route"}, 64'(ar_m), 64'(exp_m));
        end
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input bit w_first, output logic [1:0] resp);
        int n;
        bit got, aw_hs, w_hs;
        up_aw_addr = a; up_w_data = d; up_w_strb = '1;
        if (w_first) begin
            up_w_valid = 1'b1;
            repeat (2) @(posedge clk);
            @(negedge clk);
            check("w_ready_low_before_aw", 64'(up_w_ready), 64'd0);
            @(posedge clk); #1;
        end
        up_aw_valid = 1'b1; up_w_valid = 1'b1;
        n = 0;
        while ((up_aw_valid || up_w_valid) && n < 50) begin
            @(negedge clk);
            aw_hs = up_aw_valid && up_aw_ready;
            w_hs  = up_w_valid && up_w_ready;
            @(posedge clk); #1;
            if (aw_hs) up_aw_valid = 1'b0;
            if (w_hs)  up_w_valid  = 1'b0;
            n++;
        end
        check("wr_addr_data_accepted", 64'({up_aw_valid, up_w_valid}), 64'd0);
        up_aw_valid = 1'b0; up_w_valid = 1'b0;
        up_b_ready = 1'b1; got = 1'b0; resp = 2'bxx; n = 0;
        while (!got && n < 50) begin
            @(negedge clk);
            if (up_b_valid) begin resp = up_b_resp; got = 1'b1; end
            @(posedge clk); #1;
            n++;
        end
        up_b_ready = 1'b0;
        check("wr_b_seen", 64'(got), 64'd1);
    endtask

    task automatic do_read(input logic [AW-1:0] a, output logic [DW-1:0] d,
                           output logic [1:0] resp, output int wait_cyc);
        int n;
        bit got, ar_hs;
        up_ar_addr = a; up_ar_valid = 1'b1; n = 0;
        while (up_ar_valid && n < 50) begin
            @(negedge clk);
            ar_hs = up_ar_ready;
            @(posedge clk); #1;
            if (ar_hs) up_ar_valid = 1'b0;
            n++;
        end
        check("rd_addr_accepted", 64'(up_ar_valid), 64'd0);
        up_ar_valid = 1'b0;
        up_r_ready = 1'b1; got = 1'b0; d = 'x; resp = 2'bxx; n = 0;
        while (!got && n < 50) begin
            @(negedge clk);
            if (up_r_valid) begin d = up_r_data; resp = up_r_resp; got = 1'b1; end
            else n++;
            @(posedge clk); #1;
        end
        wait_cyc = n;
        up_r_ready = 1'b0;
        check("rd_r_seen", 64'(got), 64'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    logic [1:0]    resp, resp2;
    logic [DW-1:0] rdata;
    int            wc;

    initial begin
        rst = 1'b1; aw_rdy_en = 1'b1;
        up_aw_addr = '0; up_aw_valid = 1'b0;
        up_w_data = '0; up_w_strb = '0; up_w_valid = 1'b0; up_b_ready = 1'b0;
        up_ar_addr = '0; up_ar_valid = 1'b0; up_r_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_aw_ready",  64'(up_aw_ready), 64'd1);
        check("rst_ar_ready",  64'(up_ar_ready), 64'd1);
        check("rst_b_valid",   64'(up_b_valid),  64'd0);
        check("rst_r_valid",   64'(up_r_valid),  64'd0);
        check("rst_r_data",    64'(up_r_data),   64'd0);
        check("rst_dn_valids", 64'({dn_aw_valid, dn_w_valid, dn_ar_valid}), 64'd0);
        check("rst_dn_readys", 64'({dn_b_ready, dn_r_ready}), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // one write per slave, routed only to that slave
        for (int i = 0; i < M; i++) begin
            snap();
            do_write(32'(i * 32'h1000), 32'hDEAD_0000 + 32'(i * 32'h1000), 1'b0, resp);
            check($sformatf("wr%0d_resp", i), 64'(resp), 64'd0);
            chk_route($sformatf("wr%0d", i), i, 1'b1);
        end

        // read back
        for (int i = 0; i < M; i++) begin
            snap();
            do_read(32'(i * 32'h1000), rdata, resp, wc);
            check($sformatf("rd%0d_data", i), 64'(rdata), 64'(32'hDEAD_0000 + 32'(i * 32'h1000)));
            check($sformatf("rd%0d_resp", i), 64'(resp), 64'd0);
            chk_route($sformatf("rd%0d", i), i, 1'b0);
        end

        // unmapped read: local DECERR one cycle after AR handshake
        snap();
        do_read(32'h0001_0000, rdata, resp, wc);
        check("rd_miss_resp", 64'(resp),  64'd3);
        check("rd_miss_data", 64'(rdata), 64'd0);
        check("rd_miss_lat",  64'(wc),    64'd0);
        chk_route("rd_miss", -1, 1'b0);

        // unmapped write with W ahead of AW
        snap();
        do_write(32'h0001_0000, 32'h5555_AAAA, 1'b1, resp);
        check("wr_miss_resp", 64'(resp), 64'd3);
        chk_route("wr_miss", -1, 1'b1);

        // concurrent write (slave 1) and read (slave 2)
        snap();
        fork
            do_write(32'h1004, 32'h1234_5678, 1'b0, resp);
            do_read(32'h2000, rdata, resp2, wc);
        join
        check("conc_wr_resp", 64'(resp),  64'd0);
        check("conc_rd_resp", 64'(resp2), 64'd0);
        check("conc_rd_data", 64'(rdata), 64'hDEAD_2000);
        chk_route("conc_wr", 1, 1'b1);
        chk_route("conc_rd", 2, 1'b0);
        do_read(32'h1004, rdata, resp, wc);
        check("conc_wr_readback", 64'(rdata), 64'h1234_5678);

        // window boundaries
        snap();
        do_read(32'h3FFF, rdata, resp, wc);
        check("bnd_3fff_resp", 64'(resp), 64'd0);
        chk_route("bnd_3fff", 3, 1'b0);
        snap();
        do_read(32'h4000, rdata, resp, wc);
        check("bnd_4000_resp", 64'(resp),  64'd3);
        check("bnd_4000_data", 64'(rdata), 64'd0);
        chk_route("bnd_4000", -1, 1'b0);

        // reset while the write is stuck forwarding AW
        aw_rdy_en = 1'b0;
        up_aw_addr = 32'h0; up_aw_valid = 1'b1;
        up_w_data = 32'hBAD0_0000; up_w_strb = '1; up_w_valid = 1'b1;
        up_b_ready = 1'b0;
        @(posedge clk); #1; up_aw_valid = 1'b0;
        @(posedge clk); #1; up_w_valid = 1'b0;
        @(negedge clk);
        check("mid_fwd_aw_valid", 64'(dn_aw_valid), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("post_rst_dn_valids", 64'({dn_aw_valid, dn_w_valid, dn_ar_valid}), 64'd0);
        check("post_rst_dn_readys", 64'({dn_b_ready, dn_r_ready}), 64'd0);
        check("post_rst_up_valids", 64'({up_b_valid, up_r_valid}), 64'd0);
        check("post_rst_idle",      64'({up_aw_ready, up_ar_ready}), 64'd3);
        aw_rdy_en = 1'b1;
        snap();
        do_write(32'h0, 32'hCAFE_0000, 1'b0, resp);
        check("post_rst_wr_resp", 64'(resp), 64'd0);
        chk_route("post_rst_wr", 0, 1'b1);
        do_read(32'h0, rdata, resp, wc);
        check("post_rst_rd_data", 64'(rdata), 64'hCAFE_0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
